// File: rtl/ventana_cruz.sv
// Cross-window generator: raster 8-bit pixels in, five-pixel cross (A..E) out per interior centre.
// Latency: 1 cycle after accepting pixel (r,c); 2 cycles when REGISTRO_SALIDA_EN is defined.
// Backpressure: none; pix_valido=0 freezes all state and A..E hold the last window.
module ventana_cruz #(
  parameter int DATA_W = 8,
  parameter int ANCHO  = 16,
  parameter int ALTO   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valido,
  input  logic              sof,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  output logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] E,
  output logic              ventana_valida,
  output logic              fin_cuadro
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam int RW = (ALTO > 1) ? $clog2(ALTO) : 1;
  localparam logic [CW-1:0] COL_ULT = CW'(ANCHO - 1);
  localparam logic [RW-1:0] FILA_ULT = RW'(ALTO - 1);

  // Line buffers: linea1[c] holds row r-1, linea2[c] holds row r-2.
  logic [DATA_W-1:0] linea1 [ANCHO];
  logic [DATA_W-1:0] linea2 [ANCHO];

  // Column taps: sup = row r-2, med = row r-1, inf = current row r.
  logic [DATA_W-1:0] sup_d1, med_d1, med_d2, inf_d1;

  logic [CW-1:0]     col, col_act, col_sig;
  logic [RW-1:0]     fila, fila_act, fila_sig;
  logic [DATA_W-1:0] arriba1, arriba2;
  logic              emite, ultimo;

  logic [DATA_W-1:0] a1, b1, c1, d1, e1;
  logic              v1, f1;

  // Effective position of the pixel on the bus (sof forces the frame origin), taps and next position.
  always_comb begin
    col_act  = sof ? '0 : col;
    fila_act = sof ? '0 : fila;
    arriba1  = linea1[col_act];
    arriba2  = linea2[col_act];
    emite    = pix_valido && (fila_act >= RW'(2)) && (col_act >= CW'(2));
    ultimo   = (fila_act == FILA_ULT) && (col_act == COL_ULT);
    col_sig  = col_act + CW'(1);
    fila_sig = fila_act;
    if (col_act == COL_ULT) begin
      col_sig  = '0;
      fila_sig = (fila_act == FILA_ULT) ? '0 : fila_act + RW'(1);
    end
  end

  // Position counters advance only on accepted pixels; last pixel of a frame wraps to the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      fila <= '0;
    end else if (pix_valido) begin
      col  <= col_sig;
      fila <= fila_sig;
    end
  end

  // Line buffers and column shift registers; contents need no reset since rows 0/1 rewrite them first.
  always_ff @(posedge clk) begin
    if (pix_valido) begin
      linea1[col_act] <= pix_in;
      linea2[col_act] <= arriba1;
      sup_d1          <= arriba2;
      med_d1          <= arriba1;
      med_d2          <= med_d1;
      inf_d1          <= pix_in;
    end
  end

  // First output register: capture the window centred at (r-1,c-1) when (r,c) is interior-eligible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1 <= '0; b1 <= '0; c1 <= '0; d1 <= '0; e1 <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
    end else begin
      v1 <= emite;
      f1 <= emite && ultimo;
      if (emite) begin
        a1 <= sup_d1;
        b1 <= med_d2;
        c1 <= med_d1;
        d1 <= arriba1;
        e1 <= inf_d1;
      end
    end
  end

`ifdef REGISTRO_SALIDA_EN
  // Second output register: delays the whole window bundle by one more cycle, alignment unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A <= '0; B <= '0; C <= '0; D <= '0; E <= '0;
      ventana_valida <= 1'b0;
      fin_cuadro     <= 1'b0;
    end else begin
      A <= a1; B <= b1; C <= c1; D <= d1; E <= e1;
      ventana_valida <= v1;
      fin_cuadro     <= f1;
    end
  end
`else
  assign A = a1;
  assign B = b1;
  assign C = c1;
  assign D = d1;
  assign E = e1;
  assign ventana_valida = v1;
  assign fin_cuadro     = f1;
`endif

endmodule

// File: tb/tb_ventana_cruz.sv
// Self-checking bench for ventana_cruz on a 4x4 image: directed scenarios then random traffic.
// Compares every cycle against a position/image-array reference model delayed by the output latency.
// No backpressure on the DUT; the bench drives pix_valido gaps, sof and reset pulses.
module tb_ventana_cruz;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef REGISTRO_SALIDA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pix_in;
  logic          pix_valido;
  logic          sof;
  logic [DW-1:0] A, B, C, D, E;
  logic          ventana_valida;
  logic          fin_cuadro;

  always #5 clk = ~clk;

  ventana_cruz #(.DATA_W(DW), .ANCHO(W), .ALTO(H)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valido(pix_valido), .sof(sof),
    .A(A), .B(B), .C(C), .D(D), .E(E),
    .ventana_valida(ventana_valida), .fin_cuadro(fin_cuadro)
  );

  typedef struct {
    int a, b, c, d, e;
    bit v, f;
  } win_t;

  int   n_chk = 0;
  int   n_ok  = 0;
  int   mr, mc;
  int   img [H][W];
  win_t s1, s2;
  win_t wins [$];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic win_t zero_win();
    win_t z;
    z.a = 0; z.b = 0; z.c = 0; z.d = 0; z.e = 0; z.v = 1'b0; z.f = 1'b0;
    return z;
  endfunction

  task automatic compare_outputs(input win_t x);
    check("vld", int'(ventana_valida), int'(x.v));
    check("fin", int'(fin_cuadro), int'(x.f));
    check("A", int'(A), x.a);
    check("B", int'(B), x.b);
    check("C", int'(C), x.c);
    check("D", int'(D), x.d);
    check("E", int'(E), x.e);
  endtask

  // One clock: drive inputs, update the model at the edge, check outputs 1ns later.
  task automatic cycle(input bit v, input bit s, input int p);
    int r, c;
    win_t obs;
    pix_valido = v;
    sof        = s;
    pix_in     = DW'(p);
    @(posedge clk);
    s2 = s1;
    s1.v = 1'b0;
    s1.f = 1'b0;
    if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        s1.a = img[r-2][c-1];
        s1.b = img[r-1][c-2];
        s1.c = img[r-1][c-1];
        s1.d = img[r-1][c];
        s1.e = img[r][c-1];
        s1.v = 1'b1;
        s1.f = (r == H-1) && (c == W-1);
      end
      if (c == W-1) begin
        mc = 0;
        mr = (r == H-1) ? 0 : r + 1;
      end else begin
        mc = c + 1;
        mr = r;
      end
    end
    #1;
    compare_outputs((LAT == 1) ? s1 : s2);
    if (ventana_valida) begin
      obs.a = int'(A); obs.b = int'(B); obs.c = int'(C); obs.d = int'(D); obs.e = int'(E);
      obs.v = 1'b1; obs.f = fin_cuadro;
      wins.push_back(obs);
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    s1 = zero_win();
    s2 = zero_win();
    mr = 0;
    mc = 0;
    compare_outputs(s1);
    #2;
    reset = 1'b0;
  endtask

  task automatic frame(input int base, input bit with_sof, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        cycle(1'b1, with_sof && r == 0 && c == 0, 4*r + c + base);
        if (gaps) cycle(1'b0, 1'b0, 0);
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; pix_valido = 1'b0; sof = 1'b0; pix_in = '0;
    s1 = zero_win(); s2 = zero_win(); mr = 0; mc = 0;
    #3;
    compare_outputs(s1);
    #4;
    reset = 1'b0;

    // Single frame, continuous valid
    wins.delete();
    frame(0, 1'b1, 1'b0);
    idle(3);
    check("f1_nwin", wins.size(), 4);
    if (wins.size() == 4) begin
      check("f1_w0A", wins[0].a, 1);
      check("f1_w0B", wins[0].b, 4);
      check("f1_w0C", wins[0].c, 5);
      check("f1_w0D", wins[0].d, 6);
      check("f1_w0E", wins[0].e, 9);
      check("f1_w0fin", int'(wins[0].f), 0);
      check("f1_w3A", wins[3].a, 6);
      check("f1_w3C", wins[3].c, 10);
      check("f1_w3E", wins[3].e, 14);
      check("f1_w3fin", int'(wins[3].f), 1);
    end

    // Same frame with valid gaps
    wins.delete();
    frame(0, 1'b1, 1'b1);
    idle(3);
    check("gap_nwin", wins.size(), 4);
    if (wins.size() == 4) begin
      check("gap_w0C", wins[0].c, 5);
      check("gap_w3D", wins[3].d, 11);
    end

    // Two frames back-to-back, second relies on auto-wrap
    wins.delete();
    frame(0, 1'b1, 1'b0);
    frame(100, 1'b0, 1'b0);
    idle(3);
    check("wrap_nwin", wins.size(), 8);
    if (wins.size() == 8) check("wrap_w4C", wins[4].c, 105);

    // sof reasserted at pixel (2,1) of an in-progress frame
    wins.delete();
    for (int i = 0; i < 9; i++) cycle(1'b1, i == 0, i);
    frame(50, 1'b1, 1'b0);
    idle(3);
    check("sof_nwin", wins.size(), 4);
    if (wins.size() == 4) check("sof_w0C", wins[0].c, 55);

    // Reset while fila=2, then a full frame without sof
    for (int i = 0; i < 10; i++) cycle(1'b1, i == 0, i + 20);
    pulse_reset();
    wins.delete();
    frame(0, 1'b0, 1'b0);
    idle(3);
    check("rst_nwin", wins.size(), 4);
    if (wins.size() == 4) check("rst_w3C", wins[3].c, 10);

    // Random traffic: valid gaps, stray and mid-frame sof, occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 700) == 0) pulse_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, int'($urandom_range(0, 255)));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/ventana_cruz.md
# ventana_cruz

- Streaming window generator for the image-filter datapath.
- Accepts a raster-scan 8-bit pixel stream. Buffers two image lines and emits, per interior pixel, the five-pixel cross neighbourhood (up, left, centre, right, down) on ports A–E.
- A–E drive the five-input max/min comparator stage directly, one window per accepted pixel.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- ANCHO, 16, image width in pixels (≥3)
- ALTO, 16, image height in rows (≥3)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- pix_in  in  DATA_W  incoming pixel, raster order (row-major, left to right)
- pix_valido  in  1  pix_in accepted on this rising edge; no backpressure
- sof  in  1  start of frame; qualified by pix_valido, marks pixel (0,0)
- A  out  DATA_W  up neighbour (r-1, c)
- B  out  DATA_W  left neighbour (r, c-1)
- C  out  DATA_W  centre (r, c)
- D  out  DATA_W  right neighbour (r, c+1)
- E  out  DATA_W  down neighbour (r+1, c)
- ventana_valida  out  1  A–E hold a valid window this cycle (one-cycle pulse)
- fin_cuadro  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Internal column counter col (0..ANCHO-1) and row counter fila (0..ALTO-1) track the position of the pixel being accepted.
- Two line buffers of depth ANCHO are written on every accepted pixel and give the pixels at (fila-1, col) and (fila-2, col). Two 2-stage column shift registers provide the c-1 and c-2 taps.
- Accepting pixel (r,c) with r≥2 and c≥2 emits the window centred at (r-1, c-1):
  - A=(r-2,c-1), B=(r-1,c-2), C=(r-1,c-1), D=(r-1,c), E=(r,c-1)
- Windows are emitted for interior centres only. That gives (ANCHO-2)·(ALTO-2) windows per frame. No border padding.
- Counter stepping per accepted pixel:
  - Normal: col+1.
  - At col=ANCHO-1: col→0, fila+1.
  - At (ALTO-1, ANCHO-1): both counters →0. The next pixel is treated as (0,0) even without sof (auto-wrap).
- Pixel accepted with sof=1 is forced to position (0,0), regardless of counter state. Any in-progress frame is abandoned. No window is emitted for that pixel.
- sof without pix_valido is ignored.
- pix_valido=0: counters, buffers and shift registers hold; ventana_valida=0. A–E hold their last value.
- fin_cuadro=1 together with the window emitted for pixel (ALTO-1, ANCHO-1).

## Timing
- Reset values:
  - A–E = 0
  - ventana_valida = 0, fin_cuadro = 0
  - col = fila = 0
  - Line buffer contents are don't-care; they are never emitted before being rewritten.
- Latency: the window is registered. It appears in the cycle after the rising edge that accepts pixel (r,c). ventana_valida is high for exactly that one cycle.
- Throughput: one pixel per clock sustained. One window per eligible pixel, back-to-back.
- Reset asserted mid-frame: all outputs and counters clear asynchronously. After release, the first accepted pixel is (0,0).
- sof mid-frame: the next window appears no earlier than the acceptance of new-frame pixel (2,2).

## Configuration
- REGISTRO_SALIDA_EN:
  - Defined: adds a second output register stage on A–E, ventana_valida and fin_cuadro. Latency becomes 2 cycles after acceptance; relative alignment of all outputs is unchanged.
  - Undefined: latency is 1 cycle as specified above.

## Test plan
- ANCHO=ALTO=4, reset, one frame with pixel value 4r+c, pix_valido continuous:
  - exactly 4 windows
  - first window: A=1, B=4, C=5, D=6, E=9, one cycle after pixel 10 is accepted
  - last window: A=6, B=9, C=10, D=11, E=14, with fin_cuadro=1
- Same frame with pix_valido low every other cycle → identical window sequence and values; ventana_valida never high in a cycle without a preceding acceptance.
- Two frames back-to-back, second without sof, values 4r+c+100 → second frame yields 4 windows, first one C=105 (auto-wrap).
- sof reasserted at pixel (2,1) of frame one → no window until new pixel (2,2); next window C equals new pixel (1,1).
- reset pulsed while fila=2 → A–E=0 and ventana_valida=0 immediately; a full frame afterwards gives the correct 4 windows.
- With REGISTRO_SALIDA_EN defined, repeat the first scenario → same values, each window 2 cycles after acceptance.
